// File: rtl/rx_cfg_sched_if.sv
// Bundle between cpu-domain requesters and the configuration write scheduler.
// Requester side: req, req_wide, req_op, req_dh, req_dl, ecpu_busy.
// Receiver side:  ack, busy, tos_o, freeze_o, wr_o, op_o, freq_l_o.
// master = the requesters/receiver environment, slave = the scheduler.
interface rx_cfg_sched_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned OP_W = 11
) ();
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_wide;
  logic [NREQ*OP_W-1:0] req_op;
  logic [NREQ*16-1:0]   req_dh;
  logic [NREQ*32-1:0]   req_dl;
  logic                 ecpu_busy;
  logic [NREQ-1:0]      ack;
  logic                 busy;
  logic [31:0]          tos_o;
  logic                 freeze_o;
  logic                 wr_o;
  logic [OP_W-1:0]      op_o;
  logic                 freq_l_o;

  modport master (
    output req, req_wide, req_op, req_dh, req_dl, ecpu_busy,
    input  ack, busy, tos_o, freeze_o, wr_o, op_o, freq_l_o
  );

  modport slave (
    input  req, req_wide, req_op, req_dh, req_dl, ecpu_busy,
    output ack, busy, tos_o, freeze_o, wr_o, op_o, freq_l_o
  );
endinterface

// File: rtl/rx_cfg_sched.sv
// Configuration write scheduler: round-robin grant among cpu-domain
// requesters, then freeze / wait / write / settle strobe sequence into the
// receiver, split into high and low halves for 48-bit values, then ack.
// Ports: cpu_clk, rst_n (async active-low), bus (rx_cfg_sched_if.slave).
// All bus outputs are registered, so each lags the state register by a cycle.
module rx_cfg_sched #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned OP_W   = 11,
  parameter int unsigned GAP    = 4,
  parameter int unsigned SETTLE = 6
) (
  input  logic         cpu_clk,
  input  logic         rst_n,
  rx_cfg_sched_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned CMAX  = (GAP > SETTLE) ? GAP : SETTLE;
  localparam int unsigned CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FREEZE, S_GAP, S_WRITE, S_SETTLE, S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              phase_q, phase_d;
  logic [OP_W-1:0]   l_op_q, l_op_d;
  logic [15:0]       l_dh_q, l_dh_d;
  logic [31:0]       l_dl_q, l_dl_d;
  logic              l_wide_q, l_wide_d;

  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [31:0]       tos_q, tos_d;
  logic              freeze_q, freeze_d;
  logic              wr_q, wr_d;
  logic [OP_W-1:0]   op_out_q, op_out_d;
  logic              freq_l_q, freq_l_d;

  logic              found_c;
  logic [IDX_W-1:0]  gidx_c;
  logic [OP_W-1:0]   gop_c;
  logic [15:0]       gdh_c;
  logic [31:0]       gdl_c;
  logic              gwide_c;

  // Round-robin search: first set req bit starting at ptr+1, wrapping.
  always_comb begin
    found_c = 1'b0;
    gidx_c  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!found_c && bus.req[IDX_W'((32'(ptr_q) + k) % NREQ)]) begin
        found_c = 1'b1;
        gidx_c  = IDX_W'((32'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Payload mux for the winning requester.
  always_comb begin
    gop_c   = '0;
    gdh_c   = '0;
    gdl_c   = '0;
    gwide_c = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx_c == IDX_W'(i)) begin
        gop_c   = bus.req_op[i*OP_W +: OP_W];
        gdh_c   = bus.req_dh[i*16 +: 16];
        gdl_c   = bus.req_dl[i*32 +: 32];
        gwide_c = bus.req_wide[i];
      end
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= IDX_W'(NREQ - 1);
      grant_q  <= '0;
      phase_q  <= 1'b0;
      l_op_q   <= '0;
      l_dh_q   <= '0;
      l_dl_q   <= '0;
      l_wide_q <= 1'b0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      tos_q    <= '0;
      freeze_q <= 1'b0;
      wr_q     <= 1'b0;
      op_out_q <= '0;
      freq_l_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      phase_q  <= phase_d;
      l_op_q   <= l_op_d;
      l_dh_q   <= l_dh_d;
      l_dl_q   <= l_dl_d;
      l_wide_q <= l_wide_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      tos_q    <= tos_d;
      freeze_q <= freeze_d;
      wr_q     <= wr_d;
      op_out_q <= op_out_d;
      freq_l_q <= freq_l_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    phase_d  = phase_q;
    l_op_d   = l_op_q;
    l_dh_d   = l_dh_q;
    l_dl_d   = l_dl_q;
    l_wide_d = l_wide_q;
    ack_d    = '0;
    busy_d   = (state_q != S_IDLE);
    tos_d    = tos_q;
    freeze_d = 1'b0;
    wr_d     = 1'b0;
    op_out_d = '0;
    freq_l_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.ecpu_busy && found_c) begin
          grant_d  = gidx_c;
          l_op_d   = gop_c;
          l_dh_d   = gdh_c;
          l_dl_d   = gdl_c;
          l_wide_d = gwide_c;
          // Narrow writes skip straight to the low (only) half.
          phase_d  = !gwide_c;
          state_d  = S_FREEZE;
        end
      end
      S_FREEZE: begin
        freeze_d = 1'b1;
        tos_d    = phase_q ? l_dl_q : {16'h0000, l_dh_q};
        cnt_d    = CNT_W'(GAP - 1);
        state_d  = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_WRITE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WRITE: begin
        wr_d     = 1'b1;
        op_out_d = l_op_q;
        freq_l_d = l_wide_q & phase_q;
        cnt_d    = CNT_W'(SETTLE - 1);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!phase_q) begin
          phase_d = 1'b1;
          state_d = S_FREEZE;
        end else begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          ack_d[i] = (grant_q == IDX_W'(i));
        end
        ptr_d   = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ack      = ack_q;
  assign bus.busy     = busy_q;
  assign bus.tos_o    = tos_q;
  assign bus.freeze_o = freeze_q;
  assign bus.wr_o     = wr_q;
  assign bus.op_o     = op_out_q;
  assign bus.freq_l_o = freq_l_q;

endmodule

// File: tb/tb_rx_cfg_sched.sv
// Bench for rx_cfg_sched: directed scenarios then random traffic, every cycle
// compared against a timeline model (grant edge + fixed offsets per write kind).
module tb_rx_cfg_sched;

  localparam int unsigned NREQ = 3;
  localparam int unsigned OP_W = 11;
  localparam int G = 4;
  localparam int S = 6;
  localparam int FR1 = 1;
  localparam int WR1 = 2 + G;
  localparam int FR2 = 3 + G + S;
  localparam int WR2 = 4 + 2*G + S;
  localparam int ACK_N = 3 + G + S;
  localparam int ACK_W = 5 + 2*G + 2*S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_cfg_sched_if #(.NREQ(NREQ), .OP_W(OP_W)) bus ();

  rx_cfg_sched #(.NREQ(NREQ), .OP_W(OP_W), .GAP(G), .SETTLE(S)) dut (
    .cpu_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit              m_act = 1'b0;
  int              t0 = 0;
  int              m_g = 0;
  int              m_ptr = NREQ - 1;
  bit              m_wide = 1'b0;
  logic [OP_W-1:0] m_op = '0;
  logic [15:0]     m_dh = '0;
  logic [31:0]     m_dl = '0;
  bit              auto_drop = 1'b1;
  int              ack_log[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(int i, bit w, logic [OP_W-1:0] op, logic [15:0] dh, logic [31:0] dl);
    bus.req_wide[i]            = w;
    bus.req_op[i*OP_W +: OP_W] = op;
    bus.req_dh[i*16 +: 16]     = dh;
    bus.req_dl[i*32 +: 32]     = dl;
  endtask

  task automatic model_reset();
    m_act = 1'b0;
    m_ptr = NREQ - 1;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge,
  // then compare every output 1 ns later.
  task automatic tick();
    logic [NREQ-1:0]      s_req, s_wide, ack_e;
    logic [NREQ*OP_W-1:0] s_op;
    logic [NREQ*16-1:0]   s_dh;
    logic [NREQ*32-1:0]   s_dl;
    logic                 s_eb, s_rst;
    logic [31:0]          tos_e;
    bit                   found, fr_e, wr_e, lo_e, busy_e, tos_chk;
    int                   rel, ackr;
    s_req = bus.req;  s_wide = bus.req_wide; s_op = bus.req_op;
    s_dh = bus.req_dh; s_dl = bus.req_dl; s_eb = bus.ecpu_busy; s_rst = rst_n;
    @(posedge clk);
    cyc++;
    if (!s_rst) begin
      model_reset();
    end else begin
      ackr = m_wide ? ACK_W : ACK_N;
      if (m_act && (cyc - t0) > ackr) m_act = 1'b0;
      if (!m_act && !s_eb && s_req != '0) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (!found && s_req[j]) begin
            found = 1'b1;
            m_g = j;
          end
        end
        m_wide = s_wide[m_g];
        m_op   = s_op[m_g*OP_W +: OP_W];
        m_dh   = s_dh[m_g*16 +: 16];
        m_dl   = s_dl[m_g*32 +: 32];
        t0     = cyc;
        m_act  = 1'b1;
      end
    end
    ackr = m_wide ? ACK_W : ACK_N;
    rel  = cyc - t0;
    if (m_act && rel == ackr) m_ptr = m_g;
    #1;
    fr_e   = m_act && (rel == FR1 || (m_wide && rel == FR2));
    wr_e   = m_act && (rel == WR1 || (m_wide && rel == WR2));
    lo_e   = wr_e && m_wide && rel == WR2;
    ack_e  = (m_act && rel == ackr) ? (NREQ'(1) << m_g) : '0;
    busy_e = m_act && rel >= 1 && rel <= ackr;
    tos_chk = 1'b0;
    tos_e   = '0;
    if (m_act && rel >= FR1 && rel <= WR1) begin
      tos_chk = 1'b1;
      tos_e   = m_wide ? {16'h0000, m_dh} : m_dl;
    end else if (m_act && m_wide && rel >= FR2 && rel <= WR2) begin
      tos_chk = 1'b1;
      tos_e   = m_dl;
    end
    chk("freeze", bus.freeze_o, fr_e);
    chk("wr", bus.wr_o, wr_e);
    chk("op", bus.op_o, wr_e ? m_op : '0);
    chk("freq_l", bus.freq_l_o, lo_e);
    chk("ack", bus.ack, ack_e);
    chk("busy", bus.busy, busy_e);
    chk("excl", bus.freeze_o & bus.wr_o, 1'b0);
    if (tos_chk) chk("tos", bus.tos_o, tos_e);
    for (int i = 0; i < NREQ; i++) if (bus.ack[i]) ack_log.push_back(i);
    if (auto_drop) bus.req = bus.req & ~ack_e;
  endtask

  task automatic wait_idle(int maxc);
    int n;
    n = 0;
    while (m_act && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_timeout", m_act, 1'b0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_freeze"}, bus.freeze_o, 1'b0);
    chk({tag, "_wr"}, bus.wr_o, 1'b0);
    chk({tag, "_ack"}, bus.ack, '0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_tos"}, bus.tos_o, '0);
    chk({tag, "_op"}, bus.op_o, '0);
    chk({tag, "_freq_l"}, bus.freq_l_o, 1'b0);
  endtask

  int exp_order[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    bus.req = '0; bus.req_wide = '0; bus.req_op = '0;
    bus.req_dh = '0; bus.req_dl = '0; bus.ecpu_busy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Narrow single request on requester 1.
    set_req(1, 1'b0, 11'h004, 16'h5555, 32'h12345678);
    bus.req[1] = 1'b1;
    tick();
    wait_idle(40);

    // Wide request on requester 0.
    set_req(0, 1'b1, 11'h123, 16'hABCD, 32'h00FF00FF);
    bus.req[0] = 1'b1;
    tick();
    wait_idle(60);

    // Fairness: all requesters held high from reset.
    rst_n = 1'b0;
    model_reset();
    auto_drop = 1'b0;
    set_req(0, 1'b0, 11'h010, 16'h0, 32'hA0A0A0A0);
    set_req(1, 1'b0, 11'h011, 16'h0, 32'hB1B1B1B1);
    set_req(2, 1'b0, 11'h012, 16'h0, 32'hC2C2C2C2);
    bus.req = 3'b111;
    tick();
    rst_n = 1'b1;
    ack_log.delete();
    repeat (6*(ACK_N+1) + 2) tick();
    bus.req = '0;
    wait_idle(40);
    auto_drop = 1'b1;
    chk("fair_count_ok", ack_log.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i < ack_log.size()) chk("fair_order", ack_log[i], exp_order[i]);
    end

    // ecpu_busy defers the grant, but not an in-flight sequence.
    bus.ecpu_busy = 1'b1;
    set_req(2, 1'b1, 11'h2AA, 16'h1357, 32'h2468ACE0);
    bus.req[2] = 1'b1;
    repeat (10) tick();
    bus.ecpu_busy = 1'b0;
    repeat (6) tick();
    bus.ecpu_busy = 1'b1;
    wait_idle(60);
    bus.ecpu_busy = 1'b0;

    // Late data change after grant is ignored.
    set_req(1, 1'b0, 11'h07F, 16'h0, 32'hA5A5A5A5);
    bus.req[1] = 1'b1;
    tick();
    tick();
    set_req(1, 1'b1, 11'h001, 16'hFFFF, 32'hDEADBEEF);
    wait_idle(60);

    // Reset in cycle 8 of a wide write; requester 0 restarts from the high half.
    set_req(0, 1'b1, 11'h3C3, 16'h8642, 32'h0F0F0F0F);
    bus.req[0] = 1'b1;
    tick();
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wait_idle(60);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i]) begin
          if ($urandom_range(3) == 0) begin
            set_req(i, 1'($urandom_range(1)), OP_W'($urandom), 16'($urandom), $urandom);
            bus.req[i] = 1'b1;
          end
        end else if ($urandom_range(15) == 0) begin
          bus.req[i] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          set_req(i, 1'($urandom_range(1)), OP_W'($urandom), 16'($urandom), $urandom);
        end
      end
      bus.ecpu_busy = ($urandom_range(7) == 0);
    end
    bus.req = '0;
    bus.ecpu_busy = 1'b0;
    tick();
    wait_idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rx_cfg_sched.md
# rx_cfg_sched

Configuration write scheduler for the receiver. It arbitrates between several cpu-domain requesters that need to load values into adc_clk-domain receiver registers: RX frequency, WF frequency, gen frequency, nsamps and similar. For each granted request it issues the freeze/wait/write strobe sequence that the receiver's TOS freeze-and-sync path requires. For 48-bit values it splits the write into high and low halves, and it returns a one-cycle acknowledge when the write has settled into the adc_clk domain.

## Interface
Parameters:
- NREQ, 3, number of requesters (2..8)
- OP_W, 11, width of the op select field driven to the receiver
- GAP, 4, cycles between freeze_o and wr_o (covers 32-bit TOS sync latency, ≥1)
- SETTLE, 6, cycles after wr_o before the next freeze or ack (covers write-pulse sync, ≥1)

Ports:
- cpu_clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester request level; held high until ack
- req_wide  in  NREQ  per-requester flag: 48-bit value, two-phase write
- req_op  in  NREQ*OP_W  op select per requester, requester i at [i*OP_W +: OP_W]
- req_dh  in  NREQ*16  high 16 bits of value (used only when wide)
- req_dl  in  NREQ*32  low 32 bits of value
- ecpu_busy  in  1  the eCPU is driving its own freeze/wrReg sequence; defer new grants
- ack  out  NREQ  one-cycle pulse to the granted requester on completion
- busy  out  1  high whenever state ≠ IDLE
- tos_o  out  32  value presented to the freeze latch
- freeze_o  out  1  one-cycle freeze strobe
- wr_o  out  1  one-cycle register write strobe (wrReg2 equivalent)
- op_o  out  OP_W  op select, valid while wr_o is high, zero otherwise
- freq_l_o  out  1  0 = high-half write, 1 = low-half write; 0 for narrow writes

## Operation
Reset values:
- All outputs are 0.
- State is IDLE, phase is 0.
- Round-robin pointer is NREQ-1, so requester 0 has first priority.

State machine: IDLE → FREEZE → GAP → WRITE → SETTLE → (FREEZE | ACK) → IDLE.

- **IDLE**
  - If ecpu_busy is high, or no req bit is set, stay in IDLE.
  - Otherwise grant the first set req bit searching from ptr+1 upward, mod NREQ.
  - Latch the grant index, op, req_dh, req_dl and wide flag. Set phase to 0 (wide) or 1 (narrow). Go to FREEZE.
- **FREEZE**
  - freeze_o=1 for exactly one cycle.
  - tos_o = {16'b0, dh} when phase=0, dl when phase=1.
  - tos_o holds its value from this cycle through the end of WRITE.
- **GAP**
  - Stay GAP cycles, with a down-counter loaded on entry.
- **WRITE**
  - wr_o=1 for one cycle, with op_o = latched op and freq_l_o = phase for wide writes (0 for narrow).
- **SETTLE**
  - Stay SETTLE cycles.
  - Then, if phase=0, set phase to 1 and go to FREEZE for the low half.
  - Otherwise go to ACK.
- **ACK**
  - ack[grant]=1 for one cycle.
  - ptr ← grant.
  - Return to IDLE. A new grant is possible on the next cycle.

Request and boundary rules:
- Values are sampled only at grant. Changes to req_op, req_dh or req_dl after grant are ignored.
- A req that drops before grant is never serviced.
- A req that drops after grant still completes, and ack is still pulsed.
- ecpu_busy is evaluated only in IDLE. It does not interrupt an in-flight sequence, and the eCPU must check busy itself.
- Simultaneous requests are serviced one full sequence each, in round-robin order. No requester waits more than NREQ-1 sequences.
- Reset asserted mid-sequence immediately clears all strobes and outputs. No ack is issued, and the requester must re-request.
- Only one of freeze_o or wr_o is high in any cycle.

## Timing
Cycle 0 is the edge at which IDLE samples req high with ecpu_busy low.

Narrow write:
- freeze_o in cycle 1
- wr_o in cycle 2+GAP
- ack in cycle 3+GAP+SETTLE
- With defaults: freeze 1, wr 6, ack 13.

Wide write:
- High-half freeze in cycle 1, write in cycle 2+GAP.
- Low-half freeze in cycle 3+GAP+SETTLE, write in cycle 4+2·GAP+SETTLE.
- ack in cycle 5+2·GAP+2·SETTLE.
- With defaults: freeze 1, wr 6, freeze 13, wr 18, ack 25.

Back-to-back: after ack in cycle n, the next grant occurs at edge n+1 and its freeze_o in cycle n+2.

## Test plan
- **Narrow single request.** Reset, then req[1]=1 with op=0x004 and dl=0x12345678. Expect:
  - freeze_o in cycle 1, with tos_o=0x12345678 held through cycle 6.
  - wr_o in cycle 6, with op_o=0x004 and freq_l_o=0.
  - ack[1] in cycle 13; busy low in cycle 14.
- **Wide request.** req[0] with wide=1, dh=0xABCD, dl=0x00FF00FF. Expect:
  - tos_o=0x0000ABCD and wr_o in cycle 6 with freq_l_o=0.
  - tos_o=0x00FF00FF and wr_o in cycle 18 with freq_l_o=1.
  - ack[0] in cycle 25.
- **Fairness.** All three req bits held high from reset. Expect:
  - Acks in order 0, 1, 2, 0, 1, 2, with each narrow sequence 13 cycles apart plus 1 IDLE cycle.
  - freeze_o and wr_o never asserted together.
- **ecpu_busy deferral.** Assert ecpu_busy with req[2] high for 10 cycles. Expect no freeze_o. Release ecpu_busy; expect freeze_o 2 cycles later. Then raise ecpu_busy again mid-sequence; expect the sequence to complete with ack unaffected.
- **Late changes and reset.** First, change dl after grant; expect tos_o to keep the latched value. Second, assert rst_n=0 in cycle 8 of a wide write. Expect all outputs 0 immediately and no ack. After reset release, req[0] still high is granted first and its sequence restarts from the high half.
